// File: rtl/frame_release_mc_pkg.sv
// Shared QPI constants, header type and frame-release FSM state for frame_release_mc.
package frame_release_mc_pkg;

    localparam int LOG_FRAME_BASE_POINTER = 20;
    localparam int LOG_FRAME_NUMBER       = 4;
    localparam int LOG_FRAME_CHUNKS       = 2;
    localparam int CACHE_WIDTH            = 512;
    localparam int ADDR_WIDTH             = 32;
    localparam int MDATA_WIDTH            = 16;

    typedef enum logic [3:0] {
        TX_REQ_NONE   = 4'h0,
        TX_REQ_WRLINE = 4'h2
    } tx_req_t;

    typedef struct packed {
        tx_req_t                request_type;
        logic [ADDR_WIDTH-1:0]  address;
        logic [MDATA_WIDTH-1:0] mdata;
    } tx_header_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } frame_release_state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_release_mc_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, as one-hot and index.
module frame_release_mc_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/frame_release_mc.sv
// Multi-channel frame releaser: zeroes the first lines of each released frame via WrLine.
// FRAME_RELEASE_STATS_EN adds a per-channel cleared_count output.
module frame_release_mc
    import frame_release_mc_pkg::*;
#(
    parameter int NUM_CHANNELS     = 2,
    parameter int LOG_FRAMES       = LOG_FRAME_NUMBER,
    parameter int CHUNKS_PER_CLEAR = 1,
    parameter int PENDING_WIDTH    = LOG_FRAMES + 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CHANNELS*LOG_FRAME_BASE_POINTER-1:0] frame_base_pointer,
    input  logic [NUM_CHANNELS-1:0]                  release_frame,
    output logic                                     write_request,
    output tx_header_t                               write_header,
    output logic [CACHE_WIDTH-1:0]                   write_data,
    input  logic                                     write_grant,
    output logic [NUM_CHANNELS-1:0]                  overflow,
    output logic                                     idle
`ifdef FRAME_RELEASE_STATS_EN
    ,
    output logic [NUM_CHANNELS*32-1:0]               cleared_count
`endif
);

    localparam int SEL_W  = sel_width(NUM_CHANNELS);
    localparam int ADDR_W = LOG_FRAME_BASE_POINTER + LOG_FRAMES + LOG_FRAME_CHUNKS;
    localparam logic [PENDING_WIDTH-1:0]    PENDING_MAX = '1;
    localparam logic [LOG_FRAME_CHUNKS-1:0] LAST_CHUNK  = LOG_FRAME_CHUNKS'(CHUNKS_PER_CLEAR - 1);

    frame_release_state_t          state_q, state_d;
    logic [SEL_W-1:0]              sel_q, sel_d;
    logic [SEL_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [LOG_FRAME_CHUNKS-1:0]   chunk_q, chunk_d;
    logic [PENDING_WIDTH-1:0]      pending_q [NUM_CHANNELS];
    logic [PENDING_WIDTH-1:0]      pending_d [NUM_CHANNELS];
    logic [LOG_FRAMES-1:0]         frame_idx_q [NUM_CHANNELS];
    logic [LOG_FRAMES-1:0]         frame_idx_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]       overflow_q, overflow_d;

    logic [NUM_CHANNELS-1:0]       busy;
    logic [NUM_CHANNELS-1:0]       arb_onehot;
    logic [SEL_W-1:0]              arb_idx;
    logic                          last_grant;
    logic [NUM_CHANNELS-1:0]       done;
    logic [LOG_FRAME_BASE_POINTER-1:0] cur_base;
    logic [LOG_FRAMES-1:0]         cur_frame;
    logic [ADDR_W-1:0]             addr_bits;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_busy
            assign busy[gi] = (pending_q[gi] != '0);
            assign done[gi] = last_grant && (sel_q == SEL_W'(gi));
        end
    endgenerate

    frame_release_mc_rr_arbiter #(
        .N     (NUM_CHANNELS),
        .IDX_W (SEL_W)
    ) u_arb (
        .req          (busy),
        .ptr          (rr_ptr_q),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx)
    );

    assign last_grant = (state_q == ISSUE) && write_grant && (chunk_q == LAST_CHUNK);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        chunk_d     = chunk_q;
        pending_d   = pending_q;
        frame_idx_d = frame_idx_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (|arb_onehot) begin
                    sel_d   = arb_idx;
                    chunk_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (last_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = (int'(sel_q) == NUM_CHANNELS - 1) ? '0 : sel_q + 1'b1;
                end else if (write_grant) begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A release and a completion in the same cycle cancel out.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (done[c]) begin
                frame_idx_d[c] = frame_idx_q[c] + 1'b1;
            end
            if (release_frame[c] && !done[c]) begin
                if (pending_q[c] == PENDING_MAX) begin
                    overflow_d[c] = 1'b1;
                end else begin
                    pending_d[c] = pending_q[c] + 1'b1;
                end
            end else if (!release_frame[c] && done[c]) begin
                pending_d[c] = pending_q[c] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            chunk_q    <= '0;
            overflow_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                pending_q[c]   <= '0;
                frame_idx_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            chunk_q     <= chunk_d;
            overflow_q  <= overflow_d;
            pending_q   <= pending_d;
            frame_idx_q <= frame_idx_d;
        end
    end

    always_comb begin
        cur_base  = '0;
        cur_frame = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (sel_q == SEL_W'(c)) begin
                cur_base  = frame_base_pointer[c*LOG_FRAME_BASE_POINTER +: LOG_FRAME_BASE_POINTER];
                cur_frame = frame_idx_q[c];
            end
        end
        addr_bits = {cur_base, cur_frame, chunk_q};
    end

    // Header is only meaningful while requesting; keep it zero otherwise.
    always_comb begin
        write_header = '0;
        if (state_q == ISSUE) begin
            write_header.request_type = TX_REQ_WRLINE;
            write_header.address      = ADDR_WIDTH'(addr_bits);
            write_header.mdata        = MDATA_WIDTH'(sel_q);
        end
    end

    assign write_request = (state_q == ISSUE);
    assign write_data    = '0;
    assign overflow      = overflow_q;
    assign idle          = (busy == '0) && (state_q == IDLE);

`ifdef FRAME_RELEASE_STATS_EN
    logic [31:0] cleared_q [NUM_CHANNELS];
    logic [31:0] cleared_d [NUM_CHANNELS];

    always_comb begin
        cleared_d = cleared_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (done[c]) begin
                cleared_d[c] = cleared_q[c] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                cleared_q[c] <= '0;
            end
        end else begin
            cleared_q <= cleared_d;
        end
    end

    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_stats
            assign cleared_count[gi*32 +: 32] = cleared_q[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_frame_release_mc.sv
// Scoreboard bench for frame_release_mc: 2 channels, 2 chunks per clear, 4-frame rings.
module tb_frame_release_mc;
    import frame_release_mc_pkg::*;

    localparam int NCH = 2;

    logic                                  clk = 1'b0;
    logic                                  reset;
    logic [NCH*LOG_FRAME_BASE_POINTER-1:0] frame_base_pointer;
    logic [NCH-1:0]                        release_frame;
    logic                                  write_request;
    tx_header_t                            write_header;
    logic [CACHE_WIDTH-1:0]                write_data;
    logic                                  write_grant;
    logic [NCH-1:0]                        overflow;
    logic                                  idle;
`ifdef FRAME_RELEASE_STATS_EN
    logic [NCH*32-1:0]                     cleared_count;
`endif

    frame_release_mc #(
        .NUM_CHANNELS     (NCH),
        .LOG_FRAMES       (2),
        .CHUNKS_PER_CLEAR (2),
        .PENDING_WIDTH    (3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .frame_base_pointer (frame_base_pointer),
        .release_frame      (release_frame),
        .write_request      (write_request),
        .write_header       (write_header),
        .write_data         (write_data),
        .write_grant        (write_grant),
        .overflow           (overflow),
        .idle               (idle)
`ifdef FRAME_RELEASE_STATS_EN
        ,
        .cleared_count      (cleared_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MDATA_WIDTH-1:0] mdata;
        logic [ADDR_WIDTH-1:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    localparam logic [19:0] BASE0 = 20'h00005;
    localparam logic [19:0] BASE1 = 20'h0000A;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Address layout: base(20) | frame(2) | chunk(2).
    task automatic push_frame(input int ch, input int frame);
        logic [31:0] base;
        base = (ch == 0) ? 32'(BASE0) : 32'(BASE1);
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.mdata = MDATA_WIDTH'(ch);
            e.addr  = (base << 4) | (32'(frame) << 2) | 32'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse(input logic [NCH-1:0] mask);
        release_frame = mask;
        @(posedge clk); #1;
        release_frame = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !idle) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'({exp_q.size() == 0, idle}), 64'(2'b11));
    endtask

    // Monitor: every accepted request is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && write_request && write_grant) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 64'(write_header.address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hdr_addr", 64'(write_header.address), 64'(e.addr));
                check("hdr_mdata", 64'(write_header.mdata), 64'(e.mdata));
                check("hdr_type", 64'(write_header.request_type), 64'(TX_REQ_WRLINE));
                check("wdata_zero", 64'(write_data == '0), 64'd1);
                $display("txn ch=%0d addr=%h", write_header.mdata, write_header.address);
            end
        end
    end

    initial begin
        int n;
        reset              = 1'b1;
        release_frame      = '0;
        write_grant        = 1'b0;
        frame_base_pointer = {BASE1, BASE0};
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 64'(write_request), 64'd0);
        check("rst_hdr", 64'(write_header), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single release on ch0 with grant held high: chunks 0,1 of frame 0.
        write_grant = 1'b1;
        push_frame(0, 0);
        pulse(2'b01);
        drain("drain_single");

        // Both channels twice; rr pointer now at 1 so ch1 goes first.
        push_frame(1, 0);
        push_frame(0, 1);
        push_frame(1, 1);
        push_frame(0, 2);
        pulse(2'b11);
        pulse(2'b11);
        drain("drain_rr");

        // ch0 frame index wraps 3 -> 0.
        push_frame(0, 3);
        push_frame(0, 0);
        pulse(2'b01);
        pulse(2'b01);
        drain("drain_wrap");

        // Overflow on ch1 with grants withheld.
        write_grant = 1'b0;
        for (int i = 0; i < 8; i++) pulse(2'b10);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_set", 64'(overflow), 64'(2'b10));
        check("stall_req", 64'(write_request), 64'd1);
        check("stall_idle", 64'(idle), 64'd0);
        push_frame(1, 2); push_frame(1, 3); push_frame(1, 0); push_frame(1, 1);
        push_frame(1, 2); push_frame(1, 3); push_frame(1, 0);
        write_grant = 1'b1;
        drain("drain_ovf");
        check("ovf_sticky", 64'(overflow), 64'(2'b10));

        // Reset during an outstanding request.
        write_grant = 1'b0;
        pulse(2'b01);
        n = 0;
        while (!write_request && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_before_rst", 64'(write_request), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_req", 64'(write_request), 64'd0);
        check("rst_async_hdr", 64'(write_header), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        write_grant = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_req", 64'(write_request), 64'd0);
        check("post_rst_idle", 64'(idle), 64'd1);
        check("post_rst_ovf", 64'(overflow), 64'd0);

        // Frame indices restart at 0 after reset.
        push_frame(1, 0);
        pulse(2'b10);
        drain("drain_post_rst");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/frame_release_mc.md
Name: frame_release_mc

Overview:
- Multi-channel, parametrised successor to the single-ring frame releaser.
- Tracks released frames for NUM_CHANNELS independent receive rings, each with its own base pointer and frame index.
- Issues WrLine requests that zero the first CHUNKS_PER_CLEAR lines of each released frame, so software sees the frame as empty.
- Sits between the per-channel frame readers and the shared QPI write arbiter; one write port, round-robin across channels.

Parameters:
- NUM_CHANNELS, 2: number of independent rings (1..8).
- LOG_FRAMES, LOG_FRAME_NUMBER: log2 of frames per ring; the frame index wraps modulo 2^LOG_FRAMES.
- CHUNKS_PER_CLEAR, 1: lines written per released frame (1..2^LOG_FRAME_CHUNKS).
- PENDING_WIDTH, LOG_FRAMES+1: width of each per-channel pending-release counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- frame_base_pointer  in  NUM_CHANNELS*LOG_FRAME_BASE_POINTER  per-channel ring base; channel c occupies slice c. Static while that channel has pending > 0.
- release_frame  in  NUM_CHANNELS  one-cycle pulse per released frame, per channel.
- write_request  out  1  clear-write request to the arbiter.
- write_header  out  tx_header_t  request_type=WrLine, mdata={channel id, zero-extended}, address per Behaviour.
- write_data  out  CACHE_WIDTH  all zeros.
- write_grant  in  1  one-cycle acceptance of the presented header.
- overflow  out  NUM_CHANNELS  sticky per-channel pending-counter overflow.
- idle  out  1  high when all pending counters are 0 and the FSM is in IDLE.

Behaviour:
Reset:
- All counters, frame indices, chunk index and rr pointer are 0; FSM in IDLE.
- Outputs at reset: write_request=0, write_header=0, overflow=0, idle=1.
- Reset mid-transaction drops write_request combinationally-from-flops at once; in-flight pending counts are lost.

Per-channel pending counter:
- Next value = pending + release_frame[c] - (grant of last chunk for c).
- Simultaneous release and completion on the same channel leaves it unchanged.
- Release while pending == max (all ones) without a same-cycle completion: counter saturates and overflow[c] is set. overflow is cleared only by reset.

FSM (IDLE, ISSUE):
- IDLE: if any pending[c] > 0, select c by round-robin starting at rr_ptr, latch sel and chunk=0, go to ISSUE. Selection is registered, so write_request asserts the cycle after selection.
- ISSUE: write_request=1.
  - Address = {base[sel], frame_idx[sel], chunk}.
  - Header and data are stable until write_grant.
  - On write_grant with chunk < CHUNKS_PER_CLEAR-1: chunk++ and stay in ISSUE; no bubble, request stays high.
  - On write_grant with the last chunk: frame_idx[sel]++ (wraps), pending[sel]--, rr_ptr = sel+1 mod NUM_CHANNELS, go to IDLE.
- Per frame: minimum 1 idle cycle, then CHUNKS_PER_CLEAR grant cycles.
- write_grant outside ISSUE is ignored.
- Fairness: a channel with pending work waits at most NUM_CHANNELS-1 frame clears.

Optional Feature:
- Macro FRAME_RELEASE_STATS_EN.
- Defined: adds output cleared_count (NUM_CHANNELS*32), a per-channel free-running count of completed frame clears. It wraps at 2^32 and resets to 0.
- Undefined: the port and its counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (qpi.vh/qpi_pkg) holds LOG_FRAME_BASE_POINTER, LOG_FRAME_NUMBER, LOG_FRAME_CHUNKS, CACHE_WIDTH, tx_header_t and the WrLine encoding.
- New package type frame_release_state_t {IDLE, ISSUE}.
- Sub-module rr_arbiter (NUM_CHANNELS requests, rr pointer input, one-hot plus index grant) is natural and reusable.

Test Plan:
- NUM_CHANNELS=1, CHUNKS_PER_CLEAR=1, base=0x5, 3 release pulses, grant 2 cycles after each request -> 3 WrLines to frame 0,1,2 with chunk 0; idle=1 afterwards.
- NUM_CHANNELS=2, both channels pulse twice, grant every request cycle -> issue order ch0,ch1,ch0,ch1; mdata channel ids alternate.
- CHUNKS_PER_CLEAR=4, one release, grant held high -> 4 back-to-back requests with chunk 0..3 and the same frame index; frame_idx increments only after chunk 3.
- LOG_FRAMES=2, 5 releases on ch0 -> frame indices 0,1,2,3,0 (wrap).
- Hold write_grant=0, pulse release 2^PENDING_WIDTH times -> overflow[0]=1, pending stays at max; release a grant -> pending decrements and overflow stays 1.
- Assert reset while write_request=1 -> write_request=0 in the same cycle; after deassert, no request until a new release pulse.
